watch_time_ctrl: RTL and testbench
==================================

Name: watch_time_ctrl

Overview:
- Timekeeping and time-setting controller for the ASIC watch.
- Sequences the seconds, minutes and hours counters from a one-cycle 1 Hz tick.
- Arbitrates between normal running and user setting (two buttons: mode, increment).
- Feeds the display driver and chime logic. All outputs are registered.

Parameters:
- HOLD_CYC, 16384: consecutive clk_i cycles inc_btn_i must stay high before auto-repeat starts; minimum 2.
- REP_CYC, 4096: clk_i cycles between auto-repeat increments; minimum 1.

Ports:
- clk_i  in  1  system clock (32.768 kHz nominal)
- rstn_i  in  1  asynchronous active-low reset
- sec_tick_i  in  1  one-cycle pulse, once per second
- mode_btn_i  in  1  mode button level, already synchronised and debounced
- inc_btn_i  in  1  increment button level, already synchronised and debounced
- sec_o  out  6  seconds, 0-59
- min_o  out  6  minutes, 0-59
- hour_o  out  5  hours, 0-23
- mode_o  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_HOUR
- blink_o  out  1  display blink for the field being set
- min_tick_o  out  1  one-cycle pulse on minute rollover in RUN

Behaviour:
- Reset is asynchronous, active-low. On reset: sec_o/min_o/hour_o = 0, mode_o = RUN, blink_o = 0, min_tick_o = 0, edge registers = 0, hold/repeat counters = 0. Reset mid-operation aborts any setting and any repeat.
- Button edges: a rising edge is the level high with the previous-cycle registered level low. An edge or tick in cycle N shows on the outputs in cycle N+1.
- State machine on mode edge: RUN -> SET_MIN -> SET_HOUR -> RUN. Encoding 3 is unreachable; if ever entered, go to RUN next cycle.
- Entering SET_MIN: sec_o cleared to 0 in the same update.
- RUN, sec_tick_i = 1:
  - sec increments; 59 -> 0 carries into min.
  - min 59 -> 0 carries into hour; hour 23 -> 0.
  - min_tick_o = 1 for exactly one cycle on every min 59 -> 0 rollover.
- SET_MIN / SET_HOUR:
  - sec_tick_i does not advance time; sec_o stays 0.
  - Each sec_tick_i toggles blink_o.
  - min_tick_o stays 0.
- Increment event: an inc edge, or an auto-repeat strobe.
  - SET_MIN: min = (min+1) mod 60; no carry into hour.
  - SET_HOUR: hour = (hour+1) mod 24.
  - RUN: ignored.
- Auto-repeat:
  - While inc_btn_i is high in a set state, hold counter counts clk_i cycles, saturating at HOLD_CYC.
  - Once HOLD_CYC consecutive high cycles are reached, an increment strobe fires.
  - After that, a strobe fires every REP_CYC cycles while the button stays high.
  - Releasing inc_btn_i, or any mode change, clears both counters.
  - Counter widths: $clog2(HOLD_CYC+1) and $clog2(REP_CYC+1).
- Simultaneous events:
  - Mode edge and inc edge/strobe in the same cycle: mode wins; the increment is dropped; counters are cleared.
  - sec_tick_i and mode edge RUN->SET_MIN in the same cycle: sec cleared to 0; the tick is discarded.
  - sec_tick_i and mode edge SET_HOUR->RUN in the same cycle: tick discarded; counting resumes on the next tick.
- Leaving a set state: blink_o forced to 0 on the RUN transition. On entering any set state blink_o starts at 1.

Test Plan (bench overrides HOLD_CYC = 8, REP_CYC = 4):
- Reset mid-run: preload 12:34:56, assert rstn_i asynchronously -> all outputs 0 immediately, mode_o = 0.
- Rollover: state 23:59:58, 2 ticks -> 23:59:59, then 00:00:00. min_tick_o high one cycle, on the second tick's update only.
- Set minutes: from 10:20:45 RUN, one mode pulse -> mode_o = 1, sec_o = 0. 42 inc pulses -> min_o = 2, hour_o still 10. Ticks during SET_MIN leave sec_o = 0 and toggle blink_o.
- Set hours with auto-repeat:
  - SET_HOUR, hour 22, hold inc_btn_i high 20 cycles -> strobes at cycles 8, 12, 16, 20 -> hour 23, 0, 1, 2.
  - Release then press 1 cycle -> hour 3.
- Conflict: mode edge and inc edge in the same cycle in SET_MIN with min = 5 -> mode_o = 2, min_o stays 5.
- Exit: mode from SET_HOUR coincident with a tick -> mode_o = 0, blink_o = 0, sec_o = 0. Next tick -> sec_o = 1.

Source files
------------

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping and time-setting controller.
// Runs sec/min/hour from a 1 Hz tick and lets the user set minutes and hours
// with a mode button and an increment button (with hold-to-repeat).
module watch_time_ctrl #(
    parameter int HOLD_CYC = 16384,
    parameter int REP_CYC  = 4096
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       sec_tick_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [4:0] hour_o,
    output logic [1:0] mode_o,
    output logic       blink_o,
    output logic       min_tick_o
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(REP_CYC + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          blink_q, blink_d;
    logic          min_tick_q, min_tick_d;
    logic          mode_btn_q, inc_btn_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;

    logic mode_edge, inc_edge, set_st, strobe, inc_ev;

    // Hold/repeat counters; a mode edge in the same cycle wins and clears them
    always_comb begin
        mode_edge = mode_btn_i & ~mode_btn_q;
        inc_edge  = inc_btn_i & ~inc_btn_q;
        set_st    = (mode_q == SET_MIN) || (mode_q == SET_HOUR);
        hold_d    = '0;
        rep_d     = '0;
        strobe    = 1'b0;
        if (set_st && inc_btn_i && !mode_edge) begin
            if (hold_q != HW'(HOLD_CYC)) begin
                hold_d = hold_q + HW'(1);
                strobe = (hold_q == HW'(HOLD_CYC - 1));
            end else begin
                hold_d = hold_q;
                if (rep_q == RW'(REP_CYC - 1)) begin
                    strobe = 1'b1;
                    rep_d  = '0;
                end else begin
                    rep_d = rep_q + RW'(1);
                end
            end
        end
        inc_ev = (inc_edge | strobe) & set_st & ~mode_edge;
    end

    // Mode sequencing, time counting and field setting
    always_comb begin
        mode_d     = mode_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        blink_d    = blink_q;
        min_tick_d = 1'b0;
        case (mode_q)
            RUN: begin
                if (mode_edge) begin
                    mode_d  = SET_MIN;
                    sec_d   = '0;
                    blink_d = 1'b1;
                end else if (sec_tick_i) begin
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d      = '0;
                            min_tick_d = 1'b1;
                            hour_d     = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_MIN: begin
                sec_d = '0;
                if (mode_edge) begin
                    mode_d  = SET_HOUR;
                    blink_d = 1'b1;
                end else begin
                    if (sec_tick_i) blink_d = ~blink_q;
                    if (inc_ev) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            SET_HOUR: begin
                sec_d = '0;
                if (mode_edge) begin
                    mode_d  = RUN;
                    blink_d = 1'b0;
                end else begin
                    if (sec_tick_i) blink_d = ~blink_q;
                    if (inc_ev) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end
            end
            default: begin
                mode_d  = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q     <= RUN;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            blink_q    <= 1'b0;
            min_tick_q <= 1'b0;
            mode_btn_q <= 1'b0;
            inc_btn_q  <= 1'b0;
            hold_q     <= '0;
            rep_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            blink_q    <= blink_d;
            min_tick_q <= min_tick_d;
            mode_btn_q <= mode_btn_i;
            inc_btn_q  <= inc_btn_i;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
        end
    end

    assign sec_o      = sec_q;
    assign min_o      = min_q;
    assign hour_o     = hour_q;
    assign mode_o     = mode_q;
    assign blink_o    = blink_q;
    assign min_tick_o = min_tick_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Directed bench for watch_time_ctrl with short hold/repeat periods.
module tb_watch_time_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       sec_tick_i = 1'b0;
    logic       mode_btn_i = 1'b0;
    logic       inc_btn_i = 1'b0;
    logic [5:0] sec_o;
    logic [5:0] min_o;
    logic [4:0] hour_o;
    logic [1:0] mode_o;
    logic       blink_o;
    logic       min_tick_o;

    int checks = 0;
    int failures = 0;

    watch_time_ctrl #(.HOLD_CYC(8), .REP_CYC(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .sec_tick_i(sec_tick_i),
        .mode_btn_i(mode_btn_i), .inc_btn_i(inc_btn_i),
        .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o), .mode_o(mode_o),
        .blink_o(blink_o), .min_tick_o(min_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, int'(hour_o), h);
        check({tag, "_min"}, int'(min_o), m);
        check({tag, "_sec"}, int'(sec_o), s);
    endtask

    // one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        sec_tick_i = 1'b1; step(); sec_tick_i = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn_i = 1'b1; step(); mode_btn_i = 1'b0; step();
    endtask

    task automatic press_inc();
        inc_btn_i = 1'b1; step(); inc_btn_i = 1'b0; step();
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; step(); step(); rstn_i = 1'b1; step();
    endtask

    // from reset state, reach h:m:s in RUN using only the buttons and ticks
    task automatic set_time(input int h, input int m, input int s);
        press_mode();
        for (int i = 0; i < m; i++) press_inc();
        press_mode();
        for (int i = 0; i < h; i++) press_inc();
        press_mode();
        for (int i = 0; i < s; i++) tick();
    endtask

    initial begin
        int strobes;
        int exp_h;

        // power-on reset
        do_reset();
        check_time("rst", 0, 0, 0);
        check("rst_mode", int'(mode_o), 0);
        check("rst_blink", int'(blink_o), 0);
        check("rst_mtick", int'(min_tick_o), 0);

        // rollover 23:59:58 -> 23:59:59 -> 00:00:00
        set_time(23, 59, 58);
        check_time("pre_roll", 23, 59, 58);
        check("pre_roll_mode", int'(mode_o), 0);
        tick();
        check_time("roll1", 23, 59, 59);
        check("roll1_mtick", int'(min_tick_o), 0);
        tick();
        check_time("roll2", 0, 0, 0);
        check("roll2_mtick", int'(min_tick_o), 1);
        step();
        check("roll_mtick_pulse", int'(min_tick_o), 0);

        // asynchronous reset mid-run from 12:34:56
        do_reset();
        set_time(12, 34, 56);
        check_time("pre_arst", 12, 34, 56);
        #2 rstn_i = 1'b0;
        #1;
        check_time("arst", 0, 0, 0);
        check("arst_mode", int'(mode_o), 0);
        check("arst_blink", int'(blink_o), 0);
        step();
        rstn_i = 1'b1;
        step();

        // set minutes from 10:20:45
        set_time(10, 20, 45);
        check_time("pre_set", 10, 20, 45);
        mode_btn_i = 1'b1; step();
        check("setmin_mode", int'(mode_o), 1);
        check("setmin_sec", int'(sec_o), 0);
        check("setmin_blink", int'(blink_o), 1);
        mode_btn_i = 1'b0; step();
        for (int i = 0; i < 42; i++) press_inc();
        check("setmin_min", int'(min_o), 2);
        check("setmin_hour", int'(hour_o), 10);
        tick();
        check("setmin_tick1_sec", int'(sec_o), 0);
        check("setmin_tick1_blink", int'(blink_o), 0);
        check("setmin_mtick", int'(min_tick_o), 0);
        tick();
        check("setmin_tick2_blink", int'(blink_o), 1);
        check("setmin_tick2_min", int'(min_o), 2);

        // conflict: mode edge and inc edge together in SET_MIN with min = 5
        for (int i = 0; i < 3; i++) press_inc();
        check("conf_pre_min", int'(min_o), 5);
        mode_btn_i = 1'b1; inc_btn_i = 1'b1; step();
        check("conf_mode", int'(mode_o), 2);
        check("conf_min", int'(min_o), 5);
        check("conf_blink", int'(blink_o), 1);
        mode_btn_i = 1'b0; inc_btn_i = 1'b0; step();
        check("conf_hour", int'(hour_o), 10);

        // auto-repeat in SET_HOUR: 11 presses to 21, press edge gives 22
        for (int i = 0; i < 11; i++) press_inc();
        check("rep_pre_hour", int'(hour_o), 21);
        strobes = 0;
        inc_btn_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c >= 8 && ((c - 8) % 4) == 0) strobes++;
            exp_h = (22 + strobes) % 24;
            check($sformatf("rep_c%0d", c), int'(hour_o), exp_h);
        end
        inc_btn_i = 1'b0; step();
        check("rep_release", int'(hour_o), 2);
        step();
        press_inc();
        check("rep_single", int'(hour_o), 3);
        check("rep_mode", int'(mode_o), 2);

        // exit SET_HOUR coincident with a tick
        mode_btn_i = 1'b1; sec_tick_i = 1'b1; step();
        check("exit_mode", int'(mode_o), 0);
        check("exit_blink", int'(blink_o), 0);
        check("exit_sec", int'(sec_o), 0);
        mode_btn_i = 1'b0; sec_tick_i = 1'b0; step();
        tick();
        check_time("exit_run", 3, 5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
